// File: rtl/nios_led_pio_ext.sv
// nios_led_pio_ext: Avalon-MM LED output port with set/clear strobes
// and an optional hardware blink engine (enabled by LED_PIO_BLINK_EN).
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-high reset
//   address    register word address (0..7)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  32-bit write data; only the low bits of each register are used
//   readdata   combinational read data, zero-extended, no side effects
//   out_port   LED drive, DATA optionally XORed with the blink pattern
//
// Register map:
//   0 DATA, 1 BLINK_MASK, 2 BLINK_PERIOD, 3 STATUS, 4 OUTSET, 5 OUTCLEAR
//   Without LED_PIO_BLINK_EN, addresses 1-3 read 0 and ignore writes.
module nios_led_pio_ext #(
    parameter int          DATA_WIDTH     = 10,
    parameter logic [31:0] RESET_VALUE    = 32'h0,
    parameter int          PRESCALE_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic                  we;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] data_q;
    logic [31:0]           data_ext;
    logic                  unused_ok;

    assign we = chipselect & ~write_n;
    assign wd = writedata[DATA_WIDTH-1:0];

    // Upper writedata bits are deliberately ignored.
    assign unused_ok = &{1'b0, writedata, PRESCALE_WIDTH[0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE[DATA_WIDTH-1:0];
        end else if (we) begin
            case (address)
                3'd0:    data_q <= wd;
                3'd4:    data_q <= data_q | wd;
                3'd5:    data_q <= data_q & ~wd;
                default: data_q <= data_q;
            endcase
        end
    end

    always_comb begin
        data_ext = '0;
        data_ext[DATA_WIDTH-1:0] = data_q;
    end

`ifdef LED_PIO_BLINK_EN

    logic [DATA_WIDTH-1:0]     mask_q;
    logic [PRESCALE_WIDTH-1:0] period_q;
    logic [PRESCALE_WIDTH-1:0] cnt_q;
    logic                      phase_q;
    logic                      period_we;
    logic [31:0]               mask_ext;
    logic [31:0]               period_ext;

    assign period_we = we && (address == 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q   <= '0;
            period_q <= '0;
        end else begin
            if (we && (address == 3'd1)) begin
                mask_q <= wd;
            end
            if (period_we) begin
                period_q <= writedata[PRESCALE_WIDTH-1:0];
            end
        end
    end

    // A period write restarts the half-period from phase 0; the >=
    // compare keeps a shrunken period from running past its wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (period_we || (period_q == '0)) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q >= period_q - PRESCALE_WIDTH'(1)) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    always_comb begin
        mask_ext = '0;
        mask_ext[DATA_WIDTH-1:0] = mask_q;
        period_ext = '0;
        period_ext[PRESCALE_WIDTH-1:0] = period_q;
    end

    assign out_port = data_q ^ (mask_q & {DATA_WIDTH{phase_q}});

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata = data_ext;
            3'd1:    readdata = mask_ext;
            3'd2:    readdata = period_ext;
            3'd3:    readdata = {31'd0, phase_q};
            default: readdata = '0;
        endcase
    end

`else

    assign out_port = data_q;

    always_comb begin
        readdata = '0;
        if (address == 3'd0) begin
            readdata = data_ext;
        end
    end

`endif

endmodule

// File: tb/tb_nios_led_pio_ext.sv
// tb_nios_led_pio_ext: self-checking bench for nios_led_pio_ext
// (DATA_WIDTH=10, RESET_VALUE=10'h155); blink checks need LED_PIO_BLINK_EN.
module tb_nios_led_pio_ext;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string         name;
        logic [31:0]   rd;
        logic [DW-1:0] outv;
    } exp_t;

    typedef struct {
        bit            wr;
        logic [2:0]    a;
        logic [31:0]   d;
        logic [31:0]   rd;
        logic [DW-1:0] outv;
        string         name;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];

    nios_led_pio_ext #(
        .DATA_WIDTH    (DW),
        .RESET_VALUE   (32'h155),
        .PRESCALE_WIDTH(24)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void add(input bit wr, input logic [2:0] a,
                                input logic [31:0] d, input logic [31:0] rd,
                                input logic [DW-1:0] o, input string n);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.rd = rd; v.outv = o; v.name = n;
        vecs.push_back(v);
    endfunction

    // Called just after a falling edge; the write commits on the next
    // rising edge and the task returns at the following falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'hDEAD_BEEF;
    endtask

    task automatic chk(input logic [2:0] a, input logic [31:0] rd,
                       input logic [DW-1:0] o, input string n);
        exp_t e;
        exp_t got;
        address = a;
        e.name = n; e.rd = rd; e.outv = o;
        sbq.push_back(e);
        #1;
        got = sbq.pop_front();
        checks++;
        if (readdata !== got.rd) begin
            errors++;
            $display("FAIL %s: readdata=%h expected=%h", got.name,
                     readdata, got.rd);
        end
        checks++;
        if (out_port !== got.outv) begin
            errors++;
            $display("FAIL %s: out_port=%h expected=%h", got.name,
                     out_port, got.outv);
        end
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset value during and after reset
        chk(3'd0, 32'h155, 10'h155, "reset_during");
        @(negedge clk);
        chk(3'd0, 32'h155, 10'h155, "reset_during2");
        reset = 1'b0;
        chk(3'd0, 32'h155, 10'h155, "reset_after");
        chk(3'd4, 32'h0, 10'h155, "reset_outset_rd");
        @(negedge clk);

        // Table: DATA / OUTSET / OUTCLEAR and reserved addresses
        add(1, 3'd0, 32'h3FF, 0, 0, "");
        add(0, 3'd0, 0, 32'h3FF, 10'h3FF, "data_wr");
        add(1, 3'd5, 32'h00F, 0, 0, "");
        add(1, 3'd4, 32'h001, 0, 0, "");
        add(0, 3'd0, 0, 32'h3F1, 10'h3F1, "set_clear");
        add(0, 3'd4, 0, 32'h0, 10'h3F1, "outset_rd0");
        add(0, 3'd5, 0, 32'h0, 10'h3F1, "outclr_rd0");
        add(0, 3'd6, 0, 32'h0, 10'h3F1, "rsv6_rd0");
        add(0, 3'd7, 0, 32'h0, 10'h3F1, "rsv7_rd0");
        add(1, 3'd6, 32'h3FF, 0, 0, "");
        add(1, 3'd0, 32'hFFFF_FCA5, 0, 0, "");
        add(0, 3'd0, 0, 32'h0A5, 10'h0A5, "upper_ignored");
        add(1, 3'd4, 32'h300, 0, 0, "");
        add(1, 3'd5, 32'h0A0, 0, 0, "");
        add(0, 3'd0, 0, 32'h305, 10'h305, "set_clr_2");
        add(1, 3'd3, 32'h1, 0, 0, "");
        add(0, 3'd3, 0, 32'h0, 10'h305, "status_ro");
`ifndef LED_PIO_BLINK_EN
        add(1, 3'd1, 32'h3FF, 0, 0, "");
        add(1, 3'd2, 32'h4, 0, 0, "");
        add(0, 3'd1, 0, 32'h0, 10'h305, "nb_mask_rd0");
        add(0, 3'd2, 0, 32'h0, 10'h305, "nb_period_rd0");
`endif

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                wr(vecs[i].a, vecs[i].d);
            end else begin
                chk(vecs[i].a, vecs[i].rd, vecs[i].outv, vecs[i].name);
                @(negedge clk);
            end
        end

`ifdef LED_PIO_BLINK_EN
        // Period 4: toggles every 4 edges after the period write
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h3);
        wr(3'd2, 32'h4);
        for (int k = 0; k <= 12; k++) begin
            int p;
            p = (k / 4) % 2;
            chk(3'd3, 32'(p), (p != 0) ? 10'h003 : 10'h000, "blink4");
            @(negedge clk);
        end
        // Mid-count shrink to period 2 restarts from phase 0
        wr(3'd2, 32'h2);
        for (int j = 0; j <= 7; j++) begin
            int p;
            p = (j / 2) % 2;
            chk(3'd3, 32'(p), (p != 0) ? 10'h003 : 10'h000, "blink2");
            @(negedge clk);
        end
        // Period 0 halts blinking
        wr(3'd2, 32'h0);
        for (int j = 0; j < 3; j++) begin
            chk(3'd3, 32'h0, 10'h000, "halted");
            @(negedge clk);
        end
        wr(3'd0, 32'h0F0);
        chk(3'd0, 32'h0F0, 10'h0F0, "halted_data");
        @(negedge clk);
        // Period 1: phase goes to 1 one edge after the write
        wr(3'd2, 32'h1);
        chk(3'd3, 32'h0, 10'h0F0, "p1_phase0");
        @(negedge clk);
        chk(3'd3, 32'h1, 10'h0F3, "p1_phase1");
`else
        // Blink registers absent: out_port follows DATA across cycles
        for (int j = 0; j < 6; j++) begin
            chk(3'd0, 32'h305, 10'h305, "nb_out_eq_data");
            @(negedge clk);
        end
        wr(3'd0, 32'h0F0);
        chk(3'd0, 32'h0F0, 10'h0F0, "nb_data");
`endif

        // Asynchronous reset: no clock edge before sampling
        reset = 1'b1;
        chk(3'd0, 32'h155, 10'h155, "async_reset");
        chk(3'd3, 32'h0, 10'h155, "async_status");
        chk(3'd2, 32'h0, 10'h155, "async_period");
        @(negedge clk);
        reset = 1'b0;
        chk(3'd1, 32'h0, 10'h155, "post_reset_mask");
        @(negedge clk);
        chk(3'd0, 32'h155, 10'h155, "post_reset_data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
